// File: rtl/sobel_pkg.sv
// Shared constants, types and arithmetic helpers for the Sobel gradient front end.
//   pixel_t : unsigned 8-bit luminance sample
//   grad_t  : signed 11-bit gradient term (range +/-1020, no overflow)
//   win_t   : 3x3 window of pixels, win[i][j], i=0 oldest row, j=0 oldest column
package sobel_pkg;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned GRAD_W = 11;

   typedef logic        [PIX_W-1:0]  pixel_t;
   typedef logic signed [GRAD_W-1:0] grad_t;
   typedef pixel_t [2:0][2:0]        win_t;

   // Zero-extend a pixel into the signed gradient width.
   function automatic grad_t pix_ext(input pixel_t p);
      return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
   endfunction

   // Weighted 1-2-1 tap sum of three pixels (max 1020).
   function automatic grad_t tap_sum(input pixel_t a, input pixel_t b, input pixel_t c);
      return pix_ext(a) + grad_t'(pix_ext(b) <<< 1) + pix_ext(c);
   endfunction

   // Absolute value; inputs are within +/-1020 so the result never overflows.
   function automatic grad_t grad_abs(input grad_t v);
      return v[GRAD_W-1] ? grad_t'(-v) : v;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage, addressed by column.
// Read is combinational from the current contents and the write lands on the
// clock edge, so a read and write to the same address in one cycle returns
// the old value (read-before-write).
//   clk   : clock
//   we    : write enable (pixel accepted)
//   addr  : column address
//   wdata : pixel to store
//   rdata : pixel previously stored at addr
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter  int unsigned DEPTH  = 640,
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  pixel_t            wdata,
   output pixel_t            rdata
);

   // Contents are never reset; no result depends on stale data.
   pixel_t mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_gradient_xy.sv
// Streaming Sobel front end: builds a 3x3 window from a raster pixel stream and
// emits |Gx| and |Gy| for every interior pixel, three register stages deep.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : pixel accepted this cycle (no backpressure)
//   in_sof    : accepted pixel is frame position (0,0)
//   in_pixel  : 8-bit luminance
//   out_valid : gx/gy/out_last valid (single-cycle pulse per result)
//   out_last  : last result of the frame
//   gx, gy    : absolute horizontal / vertical gradients, 0..1020
module sobel_gradient_xy
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_sof,
   input  logic [PIX_W-1:0]         in_pixel,
   output logic                     out_valid,
   output logic                     out_last,
   output logic signed [GRAD_W-1:0] gx,
   output logic signed [GRAD_W-1:0] gy
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);

   // S0 state: position counters and window
   logic [COL_W-1:0] col_q, col_d, pos_col;
   logic [ROW_W-1:0] row_q, row_d, pos_row;
   win_t             win_q, win_d;
   logic             win_valid_q, win_valid_d;
   logic             win_last_q, win_last_d;

   // S1 state: partial sums
   grad_t            gx_pos_q, gx_pos_d, gx_neg_q, gx_neg_d;
   grad_t            gy_pos_q, gy_pos_d, gy_neg_q, gy_neg_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s1_last_q, s1_last_d;

   // S2 state: registered outputs
   grad_t            gx_q, gx_d, gy_q, gy_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;

   pixel_t           lb0_rd, lb1_rd;

   // Position of the pixel on the input this cycle; SOF forces (0,0).
   always_comb begin
      pos_col = in_sof ? '0 : col_q;
      pos_row = in_sof ? '0 : row_q;
   end

   // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old value.
   sobel_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
      .clk   (clk),
      .we    (in_valid),
      .addr  (pos_col),
      .wdata (pixel_t'(in_pixel)),
      .rdata (lb0_rd)
   );

   sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clk   (clk),
      .we    (in_valid),
      .addr  (pos_col),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   // S0: advance counters and shift the window on an accepted pixel.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
      if (in_valid) begin
         if (pos_col == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (pos_row == ROW_W'(IMG_H - 1)) ? '0 : pos_row + ROW_W'(1);
         end else begin
            col_d = pos_col + COL_W'(1);
            row_d = pos_row;
         end
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = lb1_rd;
         win_d[1][2] = lb0_rd;
         win_d[2][2] = pixel_t'(in_pixel);
         // Border pixels never complete a window, so stale line data is unused.
         win_valid_d = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
         win_last_d  = (pos_row == ROW_W'(IMG_H - 1)) && (pos_col == COL_W'(IMG_W - 1));
      end
   end

   // S1: positive and negative weighted column/row sums.
   always_comb begin
      gx_pos_d   = tap_sum(win_q[0][2], win_q[1][2], win_q[2][2]);
      gx_neg_d   = tap_sum(win_q[0][0], win_q[1][0], win_q[2][0]);
      gy_pos_d   = tap_sum(win_q[2][0], win_q[2][1], win_q[2][2]);
      gy_neg_d   = tap_sum(win_q[0][0], win_q[0][1], win_q[0][2]);
      s1_valid_d = win_valid_q;
      s1_last_d  = win_last_q;
   end

   // S2: subtract and take magnitude; values hold between results.
   always_comb begin
      gx_d        = gx_q;
      gy_d        = gy_q;
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
         gx_d = grad_abs(gx_pos_q - gx_neg_q);
         gy_d = grad_abs(gy_pos_q - gy_neg_q);
      end
   end

   // Control and output registers with reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         gx_q        <= '0;
         gy_q        <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         gx_q        <= gx_d;
         gy_q        <= gy_d;
      end
   end

   // Datapath registers; qualified by the valid tags, so no reset needed.
   always_ff @(posedge clk) begin
      win_q    <= win_d;
      gx_pos_q <= gx_pos_d;
      gx_neg_q <= gx_neg_d;
      gy_pos_q <= gy_pos_d;
      gy_neg_q <= gy_neg_d;
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign gx        = gx_q;
   assign gy        = gy_q;

endmodule

// File: tb/tb_sobel_gradient_xy.sv
// Directed bench for sobel_gradient_xy on a 4x4 image with a scoreboard of
// expected results computed from a stored copy of the frame.
module tb_sobel_gradient_xy;

   localparam int W = 4;
   localparam int H = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_sof;
   logic [7:0]        in_pixel;
   logic              out_valid;
   logic              out_last;
   logic signed [10:0] gx;
   logic signed [10:0] gy;

   always #5 clk = ~clk;

   sobel_gradient_xy #(.IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_last  (out_last),
      .gx        (gx),
      .gy        (gy)
   );

   typedef struct {
      int gx;
      int gy;
      bit last;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   n_res   = 0;
   int   n_last  = 0;
   int   last_gx = -1;
   int   last_gy = -1;
   int   img [H][W];
   int   mrow = 0;
   int   mcol = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pix_at(input int pat, input int r, input int c);
      case (pat)
         1:       return (c >= 2) ? 255 : 0;
         2:       return (r >= 2) ? 10 : 0;
         3:       return (r >= 2) ? 0 : 10;
         default: return 100;
      endcase
   endfunction

   // Reference: store the pixel, and when it completes a window compute the
   // gradients directly from the stored image.
   task automatic model_accept(input int pix, input bit sof, input int edge_n);
      int   gxv, gyv;
      exp_t e;
      if (sof) begin
         mrow = 0;
         mcol = 0;
      end
      img[mrow][mcol] = pix;
      if (mrow >= 2 && mcol >= 2) begin
         gxv = (img[mrow-2][mcol] + 2*img[mrow-1][mcol] + img[mrow][mcol])
             - (img[mrow-2][mcol-2] + 2*img[mrow-1][mcol-2] + img[mrow][mcol-2]);
         gyv = (img[mrow][mcol-2] + 2*img[mrow][mcol-1] + img[mrow][mcol])
             - (img[mrow-2][mcol-2] + 2*img[mrow-2][mcol-1] + img[mrow-2][mcol]);
         e.gx   = (gxv < 0) ? -gxv : gxv;
         e.gy   = (gyv < 0) ? -gyv : gyv;
         e.last = (mrow == H-1) && (mcol == W-1);
         e.cyc  = edge_n + 2;
         sbq.push_back(e);
      end
      if (mcol == W-1) begin
         mcol = 0;
         mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
         mcol = mcol + 1;
      end
   endtask

   task automatic send(input int pix, input bit sof);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      in_pixel = 8'(pix);
      model_accept(pix, sof, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
      end
   endtask

   task automatic send_frame(input int pat, input bit gappy);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gappy) idle(int'($urandom_range(0, 2)));
            send(pix_at(pat, r, c), (r == 0) && (c == 0));
         end
      end
   endtask

   // Output monitor: every result is checked against the scoreboard head,
   // including the cycle in which it appears.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 0);
         end else begin
            e = sbq.pop_front();
            check("gx", 32'(gx), 32'(e.gx));
            check("gy", 32'(gy), 32'(e.gy));
            check("last", 32'(out_last), 32'(e.last));
            check("latency", 32'(cyc), 32'(e.cyc));
            n_res++;
            if (out_last === 1'b1) n_last++;
            last_gx = int'(gx);
            last_gy = int'(gy);
         end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
         check("missing_out", 32'(out_valid), 1);
         sbq.delete(0);
      end
   end

   int base_res;
   int base_last;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_gx", 32'(gx), 0);
      check("rst_gy", 32'(gy), 0);
      rst = 1'b0;
      idle(2);

      // Flat frame
      base_res = n_res; base_last = n_last;
      send_frame(0, 1'b0);
      idle(6);
      check("flat_count", 32'(n_res - base_res), 4);
      check("flat_last_count", 32'(n_last - base_last), 1);
      check("flat_gx", 32'(last_gx), 0);
      check("flat_gy", 32'(last_gy), 0);

      // Vertical step
      base_res = n_res;
      send_frame(1, 1'b0);
      idle(6);
      check("vstep_count", 32'(n_res - base_res), 4);
      check("vstep_gx", 32'(last_gx), 1020);
      check("vstep_gy", 32'(last_gy), 0);

      // Horizontal step and its inverse
      base_res = n_res;
      send_frame(2, 1'b0);
      idle(6);
      check("hstep_count", 32'(n_res - base_res), 4);
      check("hstep_gx", 32'(last_gx), 0);
      check("hstep_gy", 32'(last_gy), 40);
      base_res = n_res;
      send_frame(3, 1'b0);
      idle(6);
      check("hstep_inv_count", 32'(n_res - base_res), 4);
      check("hstep_inv_gy", 32'(last_gy), 40);

      // Vertical step with random input gaps
      base_res = n_res;
      send_frame(1, 1'b1);
      idle(6);
      check("gappy_count", 32'(n_res - base_res), 4);
      check("gappy_gx", 32'(last_gx), 1020);

      // SOF after 6 pixels, then a full flat frame
      for (int k = 0; k < 6; k++) send(50 + 20 * k, k == 0);
      base_res = n_res;
      send_frame(0, 1'b0);
      idle(6);
      check("sof_count", 32'(n_res - base_res), 4);
      check("sof_gx", 32'(last_gx), 0);
      check("sof_gy", 32'(last_gy), 0);

      // Reset right after a window completes: the in-flight result is dropped
      for (int k = 0; k < 11; k++) send(pix_at(1, k / W, k % W), k == 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst      = 1'b1;
      sbq.delete();
      mrow = 0;
      mcol = 0;
      @(negedge clk);
      check("rst_mid_ov", 32'(out_valid), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_ov2", 32'(out_valid), 0);
      base_res = n_res;
      send_frame(1, 1'b0);
      idle(6);
      check("post_rst_count", 32'(n_res - base_res), 4);
      check("post_rst_gx", 32'(last_gx), 1020);

      // Back-to-back frames
      base_res = n_res; base_last = n_last;
      send_frame(0, 1'b0);
      send_frame(2, 1'b0);
      idle(6);
      check("b2b_count", 32'(n_res - base_res), 8);
      check("b2b_last_count", 32'(n_last - base_last), 2);
      check("b2b_gy", 32'(last_gy), 40);

      check("scoreboard_drained", 32'(sbq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
